// File: rtl/disp_pkg.sv
// Purpose: shared channel ids, default dwell and the circular enabled-channel search.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package disp_pkg;

  localparam int CH_SW_SEC  = 0;
  localparam int CH_SW_HOUR = 1;
  localparam int CH_DIST    = 2;
  localparam int CH_TEMP    = 3;
  localparam int CH_HUMI    = 4;

  // One second at 100 MHz
  localparam int DWELL_DEFAULT = 100_000_000;

  localparam int MAX_CH = 16;

  localparam logic DIR_NEXT = 1'b1;
  localparam logic DIR_PREV = 1'b0;

  // Walk away from cur (forward or backward, wrapping inside n_ch) and return
  // the first enabled index; i == n_ch lands back on cur, so a lone enabled
  // channel resolves to itself. With nothing enabled cur is returned unchanged.
  function automatic logic [3:0] next_enabled(input logic [15:0] en,
                                              input logic [3:0]  cur,
                                              input int          n_ch,
                                              input logic        dir);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= MAX_CH; i++) begin
      if (i <= n_ch && !found) begin
        if (dir) idx = (int'(cur) + i) % n_ch;
        else     idx = (int'(cur) - i + n_ch) % n_ch;
        if (en[idx]) begin
          res   = 4'(idx);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// Purpose: free-running dwell counter that pulses tick once every DWELL cycles while enabled.
// Latency: tick is combinational from the count; first tick DWELL cycles after en rises or clr.
// Backpressure: none; clr restarts the full period, en low holds the count at zero.
module disp_dwell_timer #(
  parameter int DWELL = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..DWELL-1, wrapping after the tick; any restart or idle forces zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/disp_src_sel.sv
// Purpose: registered selector choosing one display source among N_CH channels (manual, auto, forced, masked).
// Latency: one cycle from any input to data_out/sel_out/sel_chg/none_en.
// Backpressure: none; one action per cycle by fixed priority, lower-priority requests that cycle are dropped.
module disp_src_sel
  import disp_pkg::*;
#(
  parameter int N_CH  = 5,
  parameter int DW    = 5,
  parameter int DWELL = DWELL_DEFAULT,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              auto_mode,
  input  logic              force_vld,
  input  logic [SELW-1:0]   force_idx,
  output logic [DW-1:0]     data_out,
  output logic [SELW-1:0]   sel_out,
  output logic              sel_chg,
  output logic              none_en
);

  logic [15:0]   en16;
  logic [3:0]    cur4;
  logic [3:0]    fidx4;
  logic [3:0]    nxt_fwd;
  logic [3:0]    nxt_bwd;
  logic          any_en;
  logic          force_ok;
  logic          tick;
  logic          clr;
  logic [SELW-1:0] sel_nxt;
  logic [DW-1:0] ch_arr [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_arr[k] = ch_data[k*DW +: DW];
  end

  assign en16     = 16'(ch_en);
  assign cur4     = 4'(sel_out);
  assign fidx4    = 4'(force_idx);
  assign any_en   = |ch_en;
  assign force_ok = (int'(fidx4) < N_CH) && en16[fidx4];
  assign nxt_fwd  = next_enabled(en16, cur4, N_CH, DIR_NEXT);
  assign nxt_bwd  = next_enabled(en16, cur4, N_CH, DIR_PREV);

  disp_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (auto_mode),
    .clr     (clr),
    .tick    (tick)
  );

  // Pick this cycle's single action by priority; accepted manual/forced moves restart the dwell
  always_comb begin
    sel_nxt = sel_out;
    clr     = 1'b0;
    if (!any_en) begin
      sel_nxt = sel_out;
    end else if (force_vld) begin
      // An invalid force still consumes the cycle: nothing below it runs
      if (force_ok) begin
        sel_nxt = SELW'(fidx4);
        clr     = 1'b1;
      end
    end else if (btn_next && btn_prev) begin
      sel_nxt = sel_out;
    end else if (btn_next) begin
      sel_nxt = SELW'(nxt_fwd);
      clr     = 1'b1;
    end else if (btn_prev) begin
      sel_nxt = SELW'(nxt_bwd);
      clr     = 1'b1;
    end else if (tick) begin
      sel_nxt = SELW'(nxt_fwd);
    end else if (!en16[cur4]) begin
      // Current source was masked off: move to the next live one
      sel_nxt = SELW'(nxt_fwd);
    end
  end

  // Register index and data together so the display never shows mismatched pairs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_out  <= '0;
      data_out <= '0;
      sel_chg  <= 1'b0;
      none_en  <= 1'b0;
    end else begin
      sel_out  <= sel_nxt;
      data_out <= any_en ? ch_arr[sel_nxt] : '0;
      sel_chg  <= (sel_nxt != sel_out);
      none_en  <= !any_en;
    end
  end

endmodule

// File: doc/disp_src_sel.md
Name: disp_src_sel

Overview:
- Parametrised, registered display-source selector in front of the FND/7-segment driver.
- Picks one of N_CH sensor/stopwatch channels (stopwatch sec, stopwatch hour, distance, temperature, humidity, ...).
- Supports manual stepping (next/prev pulses), auto-rotation with a dwell timer, direct forced selection, and a per-channel enable mask that skips unused sources.

Parameters:
- N_CH, 5, number of input channels (2..16).
- DW, 5, data width per channel.
- DWELL, 100_000_000, clk cycles per auto-rotation step (1 s at 100 MHz); minimum 2.
- SELW, $clog2(N_CH), index width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- ch_data  in  N_CH*DW  flattened channel data; channel k occupies bits [k*DW +: DW].
- ch_en  in  N_CH  channel enable mask; 1 = selectable.
- btn_next  in  1  single-cycle pulse, advance to next enabled channel.
- btn_prev  in  1  single-cycle pulse, step back to previous enabled channel.
- auto_mode  in  1  level; 1 = auto-rotation enabled.
- force_vld  in  1  single-cycle pulse, load force_idx.
- force_idx  in  SELW  forced channel index.
- data_out  out  DW  registered selected channel data.
- sel_out  out  SELW  current channel index (registered).
- sel_chg  out  1  one-cycle pulse when sel_out changes.
- none_en  out  1  registered; 1 when ch_en == 0.

Behaviour:
- Reset (reset_n low, async): sel_out=0, data_out=0, sel_chg=0, none_en=0, dwell counter=0. Counter and outputs stay cleared while reset_n is low. Operation resumes on the first clk edge after release.
- Next-enabled search: starting at sel_out+1 (or -1 for prev), circular with wrap N_CH-1 -> 0 and 0 -> N_CH-1. Returns the first index with ch_en=1. If sel_out is the only enabled channel, it returns sel_out.
- Per-cycle priority (exactly one action per cycle):
  1. force_vld: if force_idx < N_CH and ch_en[force_idx]=1, sel <= force_idx; otherwise ignored.
  2. btn_next and btn_prev both high: no move (cancel).
  3. btn_next alone: sel <= next-enabled(+1).
  4. btn_prev alone: sel <= next-enabled(-1).
  5. Auto tick: sel <= next-enabled(+1).
  6. Mask repair: ch_en[sel_out]=0 and ch_en≠0: sel <= next-enabled(+1).
  7. Otherwise hold.
- Dwell counter:
  - Counts 0..DWELL-1 while auto_mode=1. The auto tick asserts in the cycle the count equals DWELL-1, then the counter wraps to 0.
  - Cleared to 0 on any accepted force, next, or prev action, and while auto_mode=0.
  - So a manual action restarts the full dwell period.
- No enabled channel (ch_en==0): sel holds its value, all moves are ignored, and data_out <= 0. none_en=1 one cycle after the condition.
- data_out <= ch_data[sel_next] each cycle, where sel_next is the index being loaded this cycle:
  - data_out and sel_out always change together.
  - Latency from a ch_data change is 1 cycle.
- sel_chg=1 for exactly one cycle, aligned with the new sel_out, only when the value actually differs. A forced or stepped load that resolves to the same index gives no pulse.

Decomposition:
- Shared package disp_pkg:
  - Channel index localparams CH_SW_SEC=0, CH_SW_HOUR=1, CH_DIST=2, CH_TEMP=3, CH_HUMI=4.
  - Default DWELL constant.
  - A function for the circular next-enabled search (direction argument).
- One sub-module: disp_dwell_timer. Inputs: clk, reset_n, en, clr. Output: tick. Parameter: DWELL.

Test Plan:
- Reset then release, ch_data = {5'd4,5'd3,5'd2,5'd1,5'd0}, ch_en=5'b11111 -> sel_out=0, data_out=0, sel_chg=0; after 1 clk data_out=0 (ch0), no sel_chg.
- btn_next pulses x5 with ch_en=5'b10101 -> sel_out sequence 2,4,0,2,4; data_out follows 2,4,0,2,4; five sel_chg pulses. Then btn_prev from 4 -> 2.
- DWELL=4, auto_mode=1, ch_en all ones -> sel_out advances every 4 cycles 0→1→2→3→4→0. btn_next at count 2 -> immediate advance and the next auto step 4 cycles later.
- btn_next and btn_prev in the same cycle -> sel_out unchanged, no sel_chg. Also force_vld with force_idx=3 and btn_next in the same cycle -> sel_out=3. Also force_idx=6 (invalid) -> ignored.
- sel_out=2, clear ch_en[2] -> next cycle sel_out=3 with a sel_chg pulse. Then ch_en=0 -> data_out=0, none_en=1, btn_next ignored.
- Assert reset_n low mid auto-rotation (sel_out=3, counter=2) -> outputs clear asynchronously, before the next clk edge. After release the first auto step comes DWELL cycles later.
